// File: rtl/one_hot_way_select_pkg.sv
// Shared cache-control definitions: mode encoding and the index-width helper.
package one_hot_way_select_pkg;

  // Request mode encoding on req_mode
  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Ceiling log2: number of bits needed to index 'value' entries (min 1 for value >= 2).
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/one_hot_way_select_rr_free_search.sv
// Combinational round-robin free-way search.
// Scans ways ptr, ptr+1, ... wrapping modulo WAYS and reports the first way whose
// lock bit is clear. Kept standalone so victim selection can reuse it.
module rr_free_search
  import one_hot_way_select_pkg::*;
#(
  parameter  int WAYS  = 8,
  localparam int IDX_W = log2_ceil(WAYS)
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [WAYS-1:0]  lock,
  output logic             found,
  output logic [IDX_W-1:0] sel,
  output logic [WAYS-1:0]  onehot
);

  // One extra bit so ptr + offset never overflows before the modulo fold
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] cand_sum [WAYS];
  logic [IDX_W-1:0] cand_idx [WAYS];
  logic [WAYS-1:0]  cand_free;

  // Candidate way visited at search offset gi, folded back into 0..WAYS-1.
  // The fold compares against WAYS, not 2^IDX_W, so non-power-of-two sizes wrap correctly.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_cand
    assign cand_sum[gi]  = {1'b0, ptr} + SUM_W'(gi);
    assign cand_idx[gi]  = (cand_sum[gi] >= SUM_W'(WAYS))
                           ? IDX_W'(cand_sum[gi] - SUM_W'(WAYS))
                           : cand_sum[gi][IDX_W-1:0];
    assign cand_free[gi] = ~lock[cand_idx[gi]];
  end

  // Priority pick: lowest search offset wins, which is the nearest free way after ptr
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    onehot = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (!found && cand_free[k]) begin
        found = 1'b1;
        sel   = cand_idx[k];
      end
    end
    if (found) begin
      onehot = WAYS'(1) << sel;
    end
  end

endmodule

// File: rtl/one_hot_way_select.sv
// Registered, handshaked binary-to-one-hot way selector.
// Explicit mode converts req_index to a mask; round-robin mode picks the next
// unlocked way after the last pick. One result register with valid/ready on
// both sides; accept and drain may happen in the same cycle.
// Optional build macro ONE_HOT_WAY_SELECT_STATS_EN adds saturating request,
// error and round-robin counters (stat_req, stat_err, stat_rr).
module one_hot_way_select
  import one_hot_way_select_pkg::*;
#(
  parameter  int WAYS  = 8,
  localparam int IDX_W = log2_ceil(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [IDX_W-1:0] req_index,
  input  logic [WAYS-1:0]  req_lock,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WAYS-1:0]  out_onehot,
  output logic [IDX_W-1:0] out_index,
  output logic             out_err
`ifdef ONE_HOT_WAY_SELECT_STATS_EN
  ,
  output logic [31:0]      stat_req,
  output logic [31:0]      stat_err,
  output logic [31:0]      stat_rr
`endif
);

  localparam int SUM_W = IDX_W + 1;

  // Result register and round-robin pointer
  logic             out_valid_q,  out_valid_d;
  logic [WAYS-1:0]  out_onehot_q, out_onehot_d;
  logic [IDX_W-1:0] out_index_q,  out_index_d;
  logic             out_err_q,    out_err_d;
  logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;

  logic             accept;
  logic             idx_in_range;
  logic             rr_found;
  logic [IDX_W-1:0] rr_sel;
  logic [WAYS-1:0]  rr_onehot;
  logic [IDX_W-1:0] rr_ptr_inc;

  // The register can take a new result when empty or when its content drains this cycle
  assign req_ready = !out_valid_q || out_ready;
  assign accept    = req_valid && req_ready;

  // Widen before comparing so indices >= WAYS are caught even when WAYS == 2^IDX_W
  assign idx_in_range = {1'b0, req_index} < SUM_W'(WAYS);

  rr_free_search #(
    .WAYS (WAYS)
  ) u_rr_free_search (
    .ptr    (rr_ptr_q),
    .lock   (req_lock),
    .found  (rr_found),
    .sel    (rr_sel),
    .onehot (rr_onehot)
  );

  // Pointer moves past the chosen way, wrapping at WAYS-1 rather than at 2^IDX_W-1
  assign rr_ptr_inc = (rr_sel == IDX_W'(WAYS - 1)) ? '0 : rr_sel + IDX_W'(1);

  // Next-state for the result register and pointer; hold unless accepted or drained
  always_comb begin
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;
    out_index_d  = out_index_q;
    out_err_d    = out_err_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      if (req_mode == MODE_EXPLICIT) begin
        if (idx_in_range) begin
          out_onehot_d = WAYS'(1) << req_index;
          out_index_d  = req_index;
          out_err_d    = 1'b0;
        end else begin
          out_onehot_d = '0;
          out_index_d  = '0;
          out_err_d    = 1'b1;
        end
      end else if (req_mode == MODE_RR) begin
        if (rr_found) begin
          out_onehot_d = rr_onehot;
          out_index_d  = rr_sel;
          out_err_d    = 1'b0;
          rr_ptr_d     = rr_ptr_inc;
        end else begin
          // Every way locked: flag it and leave the pointer where it was
          out_onehot_d = '0;
          out_index_d  = '0;
          out_err_d    = 1'b1;
        end
      end
    end else if (out_ready) begin
      // Drained with nothing new: only valid drops, payload keeps its last value
      out_valid_d = 1'b0;
    end
  end

  // Result register and pointer state
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_index_q  <= '0;
      out_err_q    <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      out_index_q  <= out_index_d;
      out_err_q    <= out_err_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_index  = out_index_q;
  assign out_err    = out_err_q;

`ifdef ONE_HOT_WAY_SELECT_STATS_EN
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [31:0] stat_req_q, stat_req_d;
  logic [31:0] stat_err_q, stat_err_d;
  logic [31:0] stat_rr_q,  stat_rr_d;

  // Saturating counters bumped on every accept; error uses the result being registered
  always_comb begin
    stat_req_d = stat_req_q;
    stat_err_d = stat_err_q;
    stat_rr_d  = stat_rr_q;
    if (accept) begin
      if (stat_req_q != STAT_MAX) begin
        stat_req_d = stat_req_q + 32'd1;
      end
      if (out_err_d && (stat_err_q != STAT_MAX)) begin
        stat_err_d = stat_err_q + 32'd1;
      end
      if ((req_mode == MODE_RR) && (stat_rr_q != STAT_MAX)) begin
        stat_rr_d = stat_rr_q + 32'd1;
      end
    end
  end

  // Counter state
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_req_q <= '0;
      stat_err_q <= '0;
      stat_rr_q  <= '0;
    end else begin
      stat_req_q <= stat_req_d;
      stat_err_q <= stat_err_d;
      stat_rr_q  <= stat_rr_d;
    end
  end

  assign stat_req = stat_req_q;
  assign stat_err = stat_err_q;
  assign stat_rr  = stat_rr_q;
`endif

endmodule

// File: tb/tb_one_hot_way_select.sv
// Testbench for one_hot_way_select: a WAYS=8 and a WAYS=6 instance, directed
// steps followed by random traffic, all checked against a behavioural model.
module tb_one_hot_way_select;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // WAYS = 8 instance signals
  logic       a_req_valid, a_req_ready, a_req_mode, a_out_valid, a_out_ready, a_out_err;
  logic [2:0] a_req_index, a_out_index;
  logic [7:0] a_req_lock, a_out_onehot;
  // WAYS = 6 instance signals
  logic       b_req_valid, b_req_ready, b_req_mode, b_out_valid, b_out_ready, b_out_err;
  logic [2:0] b_req_index, b_out_index;
  logic [5:0] b_req_lock, b_out_onehot;
`ifdef ONE_HOT_WAY_SELECT_STATS_EN
  logic [31:0] a_stat_req, a_stat_err, a_stat_rr;
  logic [31:0] b_stat_req, b_stat_err, b_stat_rr;
`endif

  one_hot_way_select #(.WAYS(8)) u_dut8 (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_mode   (a_req_mode),
    .req_index  (a_req_index),
    .req_lock   (a_req_lock),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_onehot (a_out_onehot),
    .out_index  (a_out_index),
    .out_err    (a_out_err)
`ifdef ONE_HOT_WAY_SELECT_STATS_EN
    ,
    .stat_req   (a_stat_req),
    .stat_err   (a_stat_err),
    .stat_rr    (a_stat_rr)
`endif
  );

  one_hot_way_select #(.WAYS(6)) u_dut6 (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_mode   (b_req_mode),
    .req_index  (b_req_index),
    .req_lock   (b_req_lock),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_onehot (b_out_onehot),
    .out_index  (b_out_index),
    .out_err    (b_out_err)
`ifdef ONE_HOT_WAY_SELECT_STATS_EN
    ,
    .stat_req   (b_stat_req),
    .stat_err   (b_stat_err),
    .stat_rr    (b_stat_rr)
`endif
  );

  // Behavioural model of one selector instance
  typedef struct {
    bit     valid;
    int     onehot;
    int     index;
    bit     err;
    int     ptr;
    longint s_req;
    longint s_err;
    longint s_rr;
  } model_t;

  model_t ma, mb;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the model: search by modulo arithmetic over way numbers
  task automatic model_step(input int w, input bit rst, input bit rv, input bit ordy,
                            input bit mode, input int idx, input int lock, inout model_t m);
    bit acc;
    int pick;
    int cw;
    if (rst) begin
      m.valid = 0; m.onehot = 0; m.index = 0; m.err = 0; m.ptr = 0;
      m.s_req = 0; m.s_err = 0; m.s_rr = 0;
      return;
    end
    acc = rv && (!m.valid || ordy);
    if (!acc) begin
      if (ordy) m.valid = 0;
      return;
    end
    m.valid = 1;
    pick = -1;
    if (!mode) begin
      if (idx < w) pick = idx;
    end else begin
      for (int k = 0; k < w; k++) begin
        cw = (m.ptr + k) % w;
        if (pick < 0 && !lock[cw]) pick = cw;
      end
    end
    if (pick >= 0) begin
      m.onehot = 1 << pick;
      m.index  = pick;
      m.err    = 0;
      if (mode) m.ptr = (pick + 1) % w;
    end else begin
      m.onehot = 0;
      m.index  = 0;
      m.err    = 1;
    end
    if (m.s_req < 64'hFFFF_FFFF) m.s_req++;
    if (m.err && m.s_err < 64'hFFFF_FFFF) m.s_err++;
    if (mode && m.s_rr < 64'hFFFF_FFFF) m.s_rr++;
  endtask

  task automatic check_outputs();
    chk("a_out_valid",  32'(a_out_valid),  32'(ma.valid));
    chk("a_out_onehot", 32'(a_out_onehot), 32'(ma.onehot));
    chk("a_out_index",  32'(a_out_index),  32'(ma.index));
    chk("a_out_err",    32'(a_out_err),    32'(ma.err));
    chk("a_onehot_pop", 32'($countones(a_out_onehot) <= 1), 32'd1);
    chk("b_out_valid",  32'(b_out_valid),  32'(mb.valid));
    chk("b_out_onehot", 32'(b_out_onehot), 32'(mb.onehot));
    chk("b_out_index",  32'(b_out_index),  32'(mb.index));
    chk("b_out_err",    32'(b_out_err),    32'(mb.err));
`ifdef ONE_HOT_WAY_SELECT_STATS_EN
    chk("a_stat_req", a_stat_req, 32'(ma.s_req));
    chk("a_stat_err", a_stat_err, 32'(ma.s_err));
    chk("a_stat_rr",  a_stat_rr,  32'(ma.s_rr));
    chk("b_stat_req", b_stat_req, 32'(mb.s_req));
    chk("b_stat_err", b_stat_err, 32'(mb.s_err));
    chk("b_stat_rr",  b_stat_rr,  32'(mb.s_rr));
`endif
  endtask

  // Check ready before the edge, clock once, advance model, check registered outputs
  task automatic cycle();
    #1;
    if (!reset) begin
      chk("a_req_ready", 32'(a_req_ready), 32'(!ma.valid || a_out_ready));
      chk("b_req_ready", 32'(b_req_ready), 32'(!mb.valid || b_out_ready));
    end
    @(posedge clk);
    model_step(8, reset, a_req_valid, a_out_ready, a_req_mode, int'(a_req_index), int'(a_req_lock), ma);
    model_step(6, reset, b_req_valid, b_out_ready, b_req_mode, int'(b_req_index), int'(b_req_lock), mb);
    #1;
    check_outputs();
  endtask

  int       idx_tab [8] = '{1, 2, 0, 3, 4, 7, 6, 5};
  logic [7:0] exp_oh [8] = '{8'h02, 8'h04, 8'h01, 8'h08, 8'h10, 8'h80, 8'h40, 8'h20};

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    reset = 1'b1;
    a_req_valid = 0; a_req_mode = 0; a_req_index = 0; a_req_lock = 0; a_out_ready = 0;
    b_req_valid = 0; b_req_mode = 0; b_req_index = 0; b_req_lock = 0; b_out_ready = 0;
    @(posedge clk);
    cycle();
    cycle();
    chk("rst_valid",  32'(a_out_valid),  32'd0);
    chk("rst_onehot", 32'(a_out_onehot), 32'd0);
    chk("rst_index",  32'(a_out_index),  32'd0);
    chk("rst_err",    32'(a_out_err),    32'd0);
    reset = 1'b0;

    // Explicit mode, one result per cycle
    a_out_ready = 1; a_req_valid = 1; a_req_mode = 0;
    for (int i = 0; i < 8; i++) begin
      a_req_index = 3'(idx_tab[i]);
      cycle();
      chk("expl_onehot", 32'(a_out_onehot), 32'(exp_oh[i]));
      chk("expl_valid",  32'(a_out_valid),  32'd1);
      chk("expl_err",    32'(a_out_err),    32'd0);
    end

    // Round-robin from pointer 0
    a_req_mode = 1; a_req_lock = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_index", 32'(a_out_index), 32'(i));
    end
    a_req_lock = 8'h30;
    cycle();
    chk("rr_skip_locked", 32'(a_out_index), 32'd6);
    a_req_lock = 8'hFF;
    cycle();
    chk("rr_all_locked_err",    32'(a_out_err),    32'd1);
    chk("rr_all_locked_onehot", 32'(a_out_onehot), 32'd0);
    a_req_lock = 8'h00;
    cycle();
    chk("rr_ptr_held_7", 32'(a_out_index), 32'd7);
    cycle();
    chk("rr_wrap_0", 32'(a_out_index), 32'd0);
    a_req_valid = 0;
    cycle();

    // WAYS = 6 boundaries
    b_out_ready = 1; b_req_valid = 1; b_req_mode = 0; b_req_index = 3'd6;
    cycle();
    chk("w6_expl_err",    32'(b_out_err),    32'd1);
    chk("w6_expl_onehot", 32'(b_out_onehot), 32'd0);
    b_req_mode = 1; b_req_lock = 6'h00;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("w6_rr_index", 32'(b_out_index), 32'(i));
    end
    cycle();
    chk("w6_rr_sel5", 32'(b_out_index), 32'd5);
    cycle();
    chk("w6_rr_wrap", 32'(b_out_index), 32'd0);
    b_req_valid = 0;
    cycle();

    // Backpressure: result held, pointer frozen
    a_req_valid = 1; a_req_mode = 1; a_req_lock = 8'h00; a_out_ready = 1;
    cycle();
    a_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_ready",  32'(a_req_ready),  32'd0);
      chk("bp_valid",  32'(a_out_valid),  32'd1);
      chk("bp_onehot", 32'(a_out_onehot), 32'h02);
      chk("bp_index",  32'(a_out_index),  32'd1);
    end
    a_out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(a_req_ready), 32'd1);
    cycle();
    chk("bp_accept", 32'(a_out_index), 32'd2);

    // Reset with a held result and pointer at 3
    reset = 1'b1;
    cycle();
    chk("rst_mid_valid",  32'(a_out_valid),  32'd0);
    chk("rst_mid_onehot", 32'(a_out_onehot), 32'd0);
    reset = 1'b0;
    cycle();
    chk("rst_rr_way0", 32'(a_out_onehot), 32'h01);
    a_req_valid = 0;
    cycle();

`ifdef ONE_HOT_WAY_SELECT_STATS_EN
    // Ten requests: six explicit, four round-robin of which two hit all-locked
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    a_req_valid = 1; a_out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      a_req_mode  = (i >= 6);
      a_req_index = 3'(i);
      a_req_lock  = (i == 7 || i == 9) ? 8'hFF : 8'h00;
      cycle();
    end
    a_req_valid = 0;
    cycle();
    chk("stat_req_10", a_stat_req, 32'd10);
    chk("stat_err_2",  a_stat_err, 32'd2);
    chk("stat_rr_4",   a_stat_rr,  32'd4);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("stat_req_clr", a_stat_req, 32'd0);
    chk("stat_err_clr", a_stat_err, 32'd0);
    chk("stat_rr_clr",  a_stat_rr,  32'd0);
`endif

    // Random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 63) == 0);
      a_req_valid = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_req_mode  = 1'($urandom_range(0, 1));
      a_req_index = 3'($urandom_range(0, 7));
      a_req_lock  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
      b_req_valid = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_req_mode  = 1'($urandom_range(0, 1));
      b_req_index = 3'($urandom_range(0, 7));
      b_req_lock  = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom & $urandom);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
